// File: rtl/tlb_host_dma_sched.sv
// tlb_host_dma_sched: weighted round-robin arbiter sharing one host DMA request channel, with an
// in-order {id,len} FIFO for completion routing. Optional starvation aging: TLB_SCHED_AGING_EN.
module tlb_host_dma_sched #(
    parameter int N_REQ     = 4,
    parameter int DATA_BITS = 96,
    parameter int LEN_BITS  = 28,
    parameter int ORD_DEPTH = 16,
    parameter int AGE_MAX   = 255,
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int PW = $clog2(ORD_DEPTH)
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [N_REQ-1:0]              s_req_valid,
    output logic [N_REQ-1:0]              s_req_ready,
    input  logic [N_REQ*DATA_BITS-1:0]    s_req_data,
    input  logic [N_REQ*LEN_BITS-1:0]     s_req_len,
    input  logic [N_REQ*4-1:0]            prio,
    output logic                          m_req_valid,
    input  logic                          m_req_ready,
    output logic [DATA_BITS-1:0]          m_req_data,
    output logic [IW-1:0]                 m_req_id,
    output logic                          m_mux_valid,
    input  logic                          m_mux_ready,
    output logic [IW-1:0]                 m_mux_id,
    output logic [LEN_BITS-1:0]           m_mux_len,
    output logic [PW:0]                   ord_used
);
    logic [DATA_BITS-1:0] data_a [N_REQ];
    logic [LEN_BITS-1:0]  len_a  [N_REQ];
    logic [3:0]           prio_a [N_REQ];
    logic [IW-1:0] rr_ptr_q, rr_ptr_d, holder_q, holder_d, gnt, rr_g, aged_g, idx;
    logic [3:0] quota_q, quota_d;
    logic keep, acc, full, pop, aged_any;
    logic m_valid_q, m_valid_d;
    logic [DATA_BITS-1:0] m_data_q, m_data_d;
    logic [IW-1:0] m_id_q, m_id_d;
    logic [IW-1:0] ord_id [ORD_DEPTH];
    logic [LEN_BITS-1:0] ord_len [ORD_DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [PW:0] used_q, used_d;

    genvar i;
    for (i = 0; i < N_REQ; i++) begin : g_unpack
        assign data_a[i] = s_req_data[i*DATA_BITS +: DATA_BITS];
        assign len_a[i]  = s_req_len[i*LEN_BITS +: LEN_BITS];
        assign prio_a[i] = prio[i*4 +: 4];
    end

`ifdef TLB_SCHED_AGING_EN
    localparam logic [7:0] AGE_LIM = 8'(AGE_MAX);
    logic [7:0] age_q [N_REQ];
    logic [N_REQ-1:0] aged;
    // lowest-index aged requester wins the override
    always_comb begin
        aged = '0;
        aged_g = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            aged[k] = s_req_valid[k] && age_q[k] == AGE_LIM;
            if (aged[k]) aged_g = IW'(k);
        end
        aged_any = |aged;
    end
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int k = 0; k < N_REQ; k++) age_q[k] <= '0;
        end else begin
            for (int k = 0; k < N_REQ; k++)
                age_q[k] <= (!s_req_valid[k] || s_req_ready[k]) ? 8'd0 :
                            (age_q[k] != AGE_LIM) ? age_q[k] + 8'd1 : age_q[k];
        end
    end
`else
    assign aged_g   = '0;
    assign aged_any = 1'b0;
`endif

    always_comb begin
        rr_g = rr_ptr_q;
        idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = IW'((int'(rr_ptr_q) + k) % N_REQ);
            if (s_req_valid[idx]) rr_g = idx;
        end
    end

    always_comb begin
        full = used_q == (PW+1)'(ORD_DEPTH);
        acc = aresetn && (!m_valid_q || m_req_ready) && !full && |s_req_valid;
        keep = s_req_valid[holder_q] && quota_q != 4'd0 && !aged_any;
        gnt = keep ? holder_q : aged_any ? aged_g : rr_g;
        s_req_ready = acc ? N_REQ'(1) << gnt : '0;
        holder_d = holder_q;
        quota_d = quota_q;
        rr_ptr_d = rr_ptr_q;
        if (acc && keep) begin
            quota_d = quota_q - 4'd1;
        end else if (acc) begin
            holder_d = gnt;
            quota_d = prio_a[gnt];
            rr_ptr_d = (gnt == IW'(N_REQ - 1)) ? '0 : gnt + 1'b1;
        end else if (!s_req_valid[holder_q]) begin
            quota_d = '0;
        end
        m_valid_d = acc || (m_valid_q && !m_req_ready);
        m_data_d = acc ? data_a[gnt] : m_data_q;
        m_id_d = acc ? gnt : m_id_q;
        pop = m_mux_valid && m_mux_ready;
        used_d = used_q + (PW+1)'(acc) - (PW+1)'(pop);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rr_ptr_q  <= '0;
            holder_q  <= '0;
            quota_q   <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_id_q    <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            used_q    <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            holder_q  <= holder_d;
            quota_q   <= quota_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_id_q    <= m_id_d;
            wr_q      <= wr_q + PW'(acc);
            rd_q      <= rd_q + PW'(pop);
            used_q    <= used_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (acc) begin
            ord_id[wr_q]  <= gnt;
            ord_len[wr_q] <= len_a[gnt];
        end
    end

    assign m_req_valid = m_valid_q;
    assign m_req_data  = m_data_q;
    assign m_req_id    = m_id_q;
    assign m_mux_valid = used_q != '0;
    assign m_mux_id    = m_mux_valid ? ord_id[rd_q] : '0;
    assign m_mux_len   = m_mux_valid ? ord_len[rd_q] : '0;
    assign ord_used    = used_q;
endmodule

// File: tb/tb_tlb_host_dma_sched.sv
// tb_tlb_host_dma_sched: directed and randomized checks of the weighted round-robin DMA scheduler
// against a queue-based behavioural model.
module tb_tlb_host_dma_sched;
    localparam int N = 4, DW = 96, LW = 28, OD = 16;
`ifdef TLB_SCHED_AGING_EN
    localparam int AGE = 8;
`else
    localparam int AGE = 255;
`endif
    logic aclk = 1'b0, aresetn = 1'b0;
    logic [N-1:0] s_req_valid, s_req_ready;
    logic [N*DW-1:0] s_req_data;
    logic [N*LW-1:0] s_req_len;
    logic [N*4-1:0] prio;
    logic m_req_valid, m_req_ready, m_mux_valid, m_mux_ready;
    logic [DW-1:0] m_req_data;
    logic [1:0] m_req_id, m_mux_id;
    logic [LW-1:0] m_mux_len;
    logic [4:0] ord_used;
    int checks = 0, errors = 0;

    // model state
    int rr, holder, left, exp_g, exp_mid;
    int age [N];
    bit exp_acc, exp_switch, exp_mv;
    logic [N-1:0] exp_ready;
    logic [DW-1:0] exp_md;
    int fifo_id [$];
    logic [LW-1:0] fifo_len [$];

    tlb_host_dma_sched #(.N_REQ(N), .DATA_BITS(DW), .LEN_BITS(LW), .ORD_DEPTH(OD), .AGE_MAX(AGE)) dut (
        .aclk(aclk), .aresetn(aresetn), .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
        .s_req_data(s_req_data), .s_req_len(s_req_len), .prio(prio), .m_req_valid(m_req_valid),
        .m_req_ready(m_req_ready), .m_req_data(m_req_data), .m_req_id(m_req_id),
        .m_mux_valid(m_mux_valid), .m_mux_ready(m_mux_ready), .m_mux_id(m_mux_id),
        .m_mux_len(m_mux_len), .ord_used(ord_used));

    always #5 aclk = ~aclk;

    task automatic model_reset();
        rr = 0; holder = 0; left = 0; exp_mv = 0; exp_md = '0; exp_mid = 0;
        for (int i = 0; i < N; i++) age[i] = 0;
        fifo_id.delete(); fifo_len.delete();
    endtask

    // grant choice for the cycle about to be clocked
    task automatic model_eval();
        int aged_i;
        aged_i = -1;
        exp_acc = (!exp_mv || m_req_ready) && fifo_id.size() < OD && s_req_valid != '0;
`ifdef TLB_SCHED_AGING_EN
        for (int i = N - 1; i >= 0; i--) if (s_req_valid[i] && age[i] == AGE) aged_i = i;
`endif
        exp_switch = 1;
        exp_g = 0;
        if (aged_i >= 0) exp_g = aged_i;
        else if (left > 0 && s_req_valid[holder]) begin exp_g = holder; exp_switch = 0; end
        else for (int k = N - 1; k >= 0; k--) if (s_req_valid[(rr + k) % N]) exp_g = (rr + k) % N;
        exp_ready = exp_acc ? 4'(1 << exp_g) : 4'b0;
    endtask

    task automatic model_commit();
`ifdef TLB_SCHED_AGING_EN
        for (int i = 0; i < N; i++)
            age[i] = (!s_req_valid[i] || exp_ready[i]) ? 0 : (age[i] < AGE ? age[i] + 1 : age[i]);
`endif
        if (fifo_id.size() != 0 && m_mux_ready) begin
            void'(fifo_id.pop_front()); void'(fifo_len.pop_front());
        end
        if (exp_acc) begin
            fifo_id.push_back(exp_g);
            fifo_len.push_back(s_req_len[exp_g*LW +: LW]);
            exp_mv = 1; exp_md = s_req_data[exp_g*DW +: DW]; exp_mid = exp_g;
            if (exp_switch) begin holder = exp_g; left = prio[exp_g*4 +: 4]; rr = (exp_g + 1) % N; end
            else left--;
        end else if (m_req_ready) exp_mv = 0;
        if (!s_req_valid[holder]) left = 0;
    endtask

    task automatic rand_payload();
        for (int i = 0; i < N; i++) begin
            s_req_data[i*DW +: DW] = {$urandom, $urandom, $urandom};
            s_req_len[i*LW +: LW] = LW'($urandom);
        end
    endtask

    task automatic do_reset();
        aresetn = 0; s_req_valid = '0; m_req_ready = 0; m_mux_ready = 0; prio = '0;
        model_reset();
        @(negedge aclk); aresetn = 1;
    endtask

    task automatic test_reset();
        aresetn = 0; s_req_valid = '0; m_req_ready = 0; m_mux_ready = 0; prio = '0;
        rand_payload(); model_reset();
        #1;
        checks++; if ({m_req_valid, m_mux_valid, s_req_ready, ord_used} !== '0) begin errors++; $display("FAIL reset_ctrl got %h exp 0", {m_req_valid, m_mux_valid, s_req_ready, ord_used}); end
        @(negedge aclk); aresetn = 1;
        s_req_valid = '1; m_req_ready = 1;
        for (int c = 0; c < 5; c++) begin #1; model_eval(); model_commit(); @(negedge aclk); end
        checks++; if (ord_used !== 5'd5) begin errors++; $display("FAIL pre_reset_used got %0d exp 5", ord_used); end
        checks++; if (m_req_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_mvalid got %b exp 1", m_req_valid); end
        aresetn = 0; #1;
        checks++; if (m_req_valid !== 1'b0 || m_req_data !== '0 || m_req_id !== '0) begin errors++; $display("FAIL reset_mreq got %b %h %0d exp 0", m_req_valid, m_req_data, m_req_id); end
        checks++; if (m_mux_valid !== 1'b0 || m_mux_id !== '0 || m_mux_len !== '0) begin errors++; $display("FAIL reset_mux got %b %0d %h exp 0", m_mux_valid, m_mux_id, m_mux_len); end
        checks++; if (ord_used !== '0) begin errors++; $display("FAIL reset_used got %0d exp 0", ord_used); end
        checks++; if (s_req_ready !== '0) begin errors++; $display("FAIL reset_ready got %b exp 0", s_req_ready); end
        model_reset();
        @(negedge aclk); aresetn = 1; #1;
        model_eval();
        checks++; if (s_req_ready !== 4'b0001) begin errors++; $display("FAIL first_grant got %b exp 0001", s_req_ready); end
        model_commit(); @(negedge aclk);
    endtask

    task automatic test_rr();
        int seq [6] = '{0, 1, 2, 3, 0, 1};
        do_reset();
        rand_payload(); s_req_valid = '1; m_req_ready = 1; m_mux_ready = 0;
        for (int c = 0; c < 6; c++) begin
            #1; model_eval();
            checks++; if (s_req_ready !== 4'(1 << seq[c]) || s_req_ready !== exp_ready) begin errors++; $display("FAIL rr_grant[%0d] got %b exp %b", c, s_req_ready, 4'(1 << seq[c])); end
            if (c > 0) begin
                checks++; if (m_req_valid !== 1'b1 || m_req_id !== 2'(seq[c-1])) begin errors++; $display("FAIL rr_id[%0d] got %b/%0d exp 1/%0d", c, m_req_valid, m_req_id, seq[c-1]); end
            end
            model_commit(); @(negedge aclk);
        end
        s_req_valid = '0; m_mux_ready = 1;
        for (int c = 0; c < 6; c++) begin
            #1; model_eval();
            checks++; if (m_mux_valid !== 1'b1 || m_mux_id !== 2'(seq[c]) || m_mux_len !== fifo_len[0]) begin errors++; $display("FAIL rr_fifo[%0d] got %b/%0d/%h exp 1/%0d/%h", c, m_mux_valid, m_mux_id, m_mux_len, seq[c], fifo_len[0]); end
            model_commit(); @(negedge aclk);
        end
        #1;
        checks++; if (m_mux_valid !== 1'b0 || ord_used !== '0) begin errors++; $display("FAIL rr_drained got %b/%0d exp 0/0", m_mux_valid, ord_used); end
        @(negedge aclk);
    endtask

    task automatic test_weighted();
        int seq [13] = '{0, 3, 3, 3, 0, 3, 3, 3, 0, 3, 3, 3, 3};
        do_reset();
        rand_payload(); prio = 16'h2000; s_req_valid = 4'b1001; m_req_ready = 1; m_mux_ready = 1;
        for (int c = 0; c < 13; c++) begin
            if (c == 6) prio = 16'h3000;
            #1; model_eval();
            checks++; if (s_req_ready !== 4'(1 << seq[c]) || s_req_ready !== exp_ready) begin errors++; $display("FAIL wrr_grant[%0d] got %b exp %b", c, s_req_ready, 4'(1 << seq[c])); end
            model_commit(); @(negedge aclk);
        end
    endtask

    task automatic test_full();
        int n_acc = 0;
        do_reset();
        rand_payload(); prio = 16'($urandom); s_req_valid = '1; m_req_ready = 1; m_mux_ready = 0;
        for (int c = 0; c < 20; c++) begin
            #1; model_eval();
            checks++; if (s_req_ready !== exp_ready) begin errors++; $display("FAIL full_grant[%0d] got %b exp %b", c, s_req_ready, exp_ready); end
            if (s_req_ready != '0) n_acc++;
            model_commit(); @(negedge aclk);
        end
        checks++; if (n_acc != 16) begin errors++; $display("FAIL full_accepts got %0d exp 16", n_acc); end
        checks++; if (ord_used !== 5'd16) begin errors++; $display("FAIL full_used got %0d exp 16", ord_used); end
        m_mux_ready = 1; #1; model_eval();
        checks++; if (s_req_ready !== '0 || exp_ready !== '0) begin errors++; $display("FAIL full_pop_same got %b exp 0", s_req_ready); end
        model_commit(); @(negedge aclk);
        m_mux_ready = 0; #1; model_eval();
        checks++; if (!$onehot(s_req_ready) || s_req_ready !== exp_ready) begin errors++; $display("FAIL full_refill got %b exp %b", s_req_ready, exp_ready); end
        model_commit(); @(negedge aclk);
        #1; model_eval();
        checks++; if (s_req_ready !== '0) begin errors++; $display("FAIL full_again got %b exp 0", s_req_ready); end
        model_commit(); @(negedge aclk);
    endtask

    task automatic test_stall();
        logic [DW-1:0] d0;
        do_reset();
        rand_payload(); d0 = s_req_data[2*DW +: DW];
        s_req_valid = 4'b0100; m_req_ready = 0; m_mux_ready = 1;
        #1; model_eval();
        checks++; if (s_req_ready !== 4'b0100) begin errors++; $display("FAIL stall_first got %b exp 0100", s_req_ready); end
        model_commit(); @(negedge aclk);
        for (int c = 0; c < 10; c++) begin
            rand_payload(); #1; model_eval();
            checks++; if (m_req_valid !== 1'b1 || m_req_data !== d0 || m_req_id !== 2'd2) begin errors++; $display("FAIL stall_hold[%0d] got %b/%h/%0d exp 1/%h/2", c, m_req_valid, m_req_data, m_req_id, d0); end
            checks++; if (s_req_ready !== '0) begin errors++; $display("FAIL stall_ready[%0d] got %b exp 0", c, s_req_ready); end
            model_commit(); @(negedge aclk);
        end
        m_req_ready = 1; d0 = s_req_data[2*DW +: DW]; #1; model_eval();
        checks++; if (s_req_ready !== 4'b0100) begin errors++; $display("FAIL stall_release got %b exp 0100", s_req_ready); end
        model_commit(); @(negedge aclk);
        s_req_valid = '0; #1; model_eval();
        checks++; if (m_req_valid !== 1'b1 || m_req_data !== d0) begin errors++; $display("FAIL stall_next got %b/%h exp 1/%h", m_req_valid, m_req_data, d0); end
        model_commit(); @(negedge aclk);
        #1;
        checks++; if (m_req_valid !== 1'b0) begin errors++; $display("FAIL stall_drop got %b exp 0", m_req_valid); end
        @(negedge aclk);
    endtask

`ifdef TLB_SCHED_AGING_EN
    task automatic test_aging();
        do_reset();
        rand_payload(); prio = 16'h000F; s_req_valid = 4'b0011; m_req_ready = 1; m_mux_ready = 1;
        for (int c = 0; c < 9; c++) begin
            #1; model_eval();
            checks++; if (s_req_ready !== (c < 8 ? 4'b0001 : 4'b0010) || s_req_ready !== exp_ready) begin errors++; $display("FAIL aging[%0d] got %b exp %b", c, s_req_ready, c < 8 ? 4'b0001 : 4'b0010); end
            model_commit(); @(negedge aclk);
        end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rand_payload();
            for (int i = 0; i < N; i++) s_req_valid[i] = $urandom_range(0, 3) != 0;
            if (c % 40 == 0) prio = 16'($urandom);
            m_req_ready = $urandom_range(0, 3) != 0;
            m_mux_ready = (c < 300) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
            #1; model_eval();
            checks++; if (s_req_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready[%0d] got %b exp %b", c, s_req_ready, exp_ready); end
            checks++; if (m_req_valid !== exp_mv || (exp_mv && (m_req_data !== exp_md || m_req_id !== 2'(exp_mid)))) begin errors++; $display("FAIL rnd_mreq[%0d] got %b/%h/%0d exp %b/%h/%0d", c, m_req_valid, m_req_data, m_req_id, exp_mv, exp_md, exp_mid); end
            checks++; if (ord_used !== 5'(fifo_id.size()) || m_mux_valid !== (fifo_id.size() != 0)) begin errors++; $display("FAIL rnd_used[%0d] got %0d/%b exp %0d", c, ord_used, m_mux_valid, fifo_id.size()); end
            if (fifo_id.size() != 0) begin
                checks++; if (m_mux_id !== 2'(fifo_id[0]) || m_mux_len !== fifo_len[0]) begin errors++; $display("FAIL rnd_head[%0d] got %0d/%h exp %0d/%h", c, m_mux_id, m_mux_len, fifo_id[0], fifo_len[0]); end
            end
            model_commit(); @(negedge aclk);
        end
    endtask

    initial begin
        s_req_data = '0; s_req_len = '0;
        test_reset();
        test_rr();
        test_weighted();
        test_full();
        test_stall();
`ifdef TLB_SCHED_AGING_EN
        test_aging();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
